regfile_wb_arbiter: RTL and testbench
=====================================

# regfile_wb_arbiter

Write-back arbiter and scoreboard for the 64-bit integer register file. Shares the register file's single write port between NUM_SRC writeback sources (ALU, LSU, MDU) using round-robin valid/ready handshakes, and drives one registered write per cycle. Tracks a busy bit per architectural register so that decode can stall on RAW and WAW hazards against in-flight long-latency results. Sits between the execute/writeback units and the register file write port; decode reads the busy queries.

## Interface
- NUM_SRC, 3, number of writeback sources; index 0 = ALU, 1 = LSU, 2 = MDU.
- XLEN, 64, data width.

- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wb_valid_i  in  NUM_SRC  per-source writeback request.
- wb_addr_i  in  5*NUM_SRC  per-source destination register; source s is at [5s+:5].
- wb_data_i  in  XLEN*NUM_SRC  per-source result; source s is at [XLEN*s+:XLEN].
- wb_ready_o  out  NUM_SRC  one-hot grant; the handshake fires when valid and ready are both high.
- rf_wr_en_o  out  1  register file write enable, registered.
- rf_rd_addr_o  out  5  register file write address, registered.
- rf_rd_data_o  out  XLEN  register file write data, registered.
- issue_valid_i  in  1  decode issues an instruction that writes rd.
- issue_rd_i  in  5  destination of the issuing instruction.
- rs1_addr_i, rs2_addr_i, rd_addr_i  in  5 each  decode hazard queries.
- rs1_busy_o, rs2_busy_o, rd_busy_o  out  1 each  combinational busy bit of the queried register; always 0 for x0.

## Operation
- Arbitration:
  - Round-robin among asserted wb_valid_i.
  - The search starts at last_grant+1 (mod NUM_SRC); the first valid source found wins.
  - wb_ready_o is one-hot on the winner, or all zero when nothing is valid.
  - wb_ready_o depends combinationally on wb_valid_i. A source must not make valid depend on ready.
  - last_grant updates only on a fired handshake.
  - Reset value of last_grant is NUM_SRC-1, so source 0 has first priority.
- Sources hold addr and data stable while valid and not ready. A valid request may not be withdrawn before it is granted.
- Output stage:
  - One register stage that is always accepting, because the register file never stalls.
  - On a fired handshake, the next cycle has rf_wr_en_o=1 and carries the granted addr/data. Otherwise the next cycle has rf_wr_en_o=0, and addr/data hold their previous values.
  - A handshake with wb_addr=0 is accepted and consumed, but rf_wr_en_o stays 0 for it.
- Scoreboard (busy[31:1]):
  - Set: issue_valid_i with issue_rd_i≠0 sets busy[issue_rd_i] at the clock edge.
  - Clear: rf_wr_en_o=1 clears busy[rf_rd_addr_o] at the same edge at which the register file captures the data.
  - Set and clear of the same register in the same cycle: set wins.
  - Decode must not issue to a register with rd_busy_o=1 (no WAW). If it does, the set is a no-op because the bit is already set. A bench assertion flags this case.
- Busy queries read the current busy bits. There is no bypass: a register stays busy through the cycle in which rf_wr_en_o writes it.

## Timing
- Reset (async assert, sync deassert handled upstream):
  - wb_ready_o=0 while rst_n=0.
  - rf_wr_en_o=0, rf_rd_addr_o=0, rf_rd_data_o=0.
  - All busy bits 0, so all *_busy_o=0.
  - last_grant=NUM_SRC-1.
- Reset mid-operation: all pending busy bits and the in-flight output write are discarded. Sources must also be reset.
- Latency:
  - Handshake in cycle t → rf_wr_en_o in cycle t+1.
  - Register file updated and busy bit cleared at the end of t+1.
  - Value readable from the register file, and busy=0, in cycle t+2.
- Throughput: one write per cycle. With all NUM_SRC sources continuously valid, each source is granted once every NUM_SRC cycles.
- Issue-to-busy: issue in cycle t → busy visible from t+1.

## Test plan
- Reset: hold rst_n=0 mid-traffic, with busy[5] set and rf_wr_en_o=1 → outputs zero asynchronously and busy[5]=0. After release, the first grant goes to source 0 when all sources are valid.
- Single source: ALU valid with addr=7, data=0xDEADBEEF_00000001 in cycle t → wb_ready_o=001 in t; in t+1 rf_wr_en_o=1, rf_rd_addr_o=7, rf_rd_data_o=0xDEADBEEF_00000001.
- Round-robin: all three sources valid continuously for 6 cycles → grants 0,1,2,0,1,2. LSU held valid but ungranted keeps addr/data stable until its grant.
- Scoreboard:
  - Issue rd=12 in cycle 0 → rs1_busy_o=1 for rs1_addr_i=12 from cycle 1.
  - MDU handshake for rd=12 in cycle 10 → busy still 1 in cycle 11, 0 in cycle 12.
- Simultaneous set and clear: rf_wr_en_o writing rd=3 in the same cycle as issue_valid_i with issue_rd_i=3 → busy[3]=1 afterward.
- x0 handling:
  - Issue rd=0 → no busy bit set, and rs1_busy_o=0 for query 0.
  - Writeback to addr 0 → handshake fires, and rf_wr_en_o stays 0 the next cycle.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter with register-busy scoreboard: round-robin shares the single
// register file write port among NUM_SRC sources and tracks in-flight destinations.
module regfile_wb_arbiter #(
    parameter int NUM_SRC = 3,
    parameter int XLEN    = 64
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_SRC-1:0]        wb_valid_i,
    input  logic [5*NUM_SRC-1:0]      wb_addr_i,
    input  logic [XLEN*NUM_SRC-1:0]   wb_data_i,
    output logic [NUM_SRC-1:0]        wb_ready_o,
    output logic                      rf_wr_en_o,
    output logic [4:0]                rf_rd_addr_o,
    output logic [XLEN-1:0]           rf_rd_data_o,
    input  logic                      issue_valid_i,
    input  logic [4:0]                issue_rd_i,
    input  logic [4:0]                rs1_addr_i,
    input  logic [4:0]                rs2_addr_i,
    input  logic [4:0]                rd_addr_i,
    output logic                      rs1_busy_o,
    output logic                      rs2_busy_o,
    output logic                      rd_busy_o
);

    localparam int IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [IW-1:0]      last_grant_reg;
    logic [IW-1:0]      grant_idx;
    logic               grant_found;
    logic [NUM_SRC-1:0] grant_onehot;
    logic [4:0]         grant_addr;
    logic [XLEN-1:0]    grant_data;

    logic               wr_en_reg;
    logic [4:0]         wr_addr_reg;
    logic [XLEN-1:0]    wr_data_reg;

    logic [31:1]        busy_reg;
    logic [31:1]        busy_next;
    logic [31:0]        busy_vec;

    // Search starts just after the last winner so every source gets a turn.
    always_comb begin
        int cand;
        cand         = 0;
        grant_found  = 1'b0;
        grant_idx    = last_grant_reg;
        grant_onehot = '0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            cand = int'(last_grant_reg) + k;
            if (cand >= NUM_SRC) begin
                cand = cand - NUM_SRC;
            end
            if (!grant_found && wb_valid_i[cand]) begin
                grant_found = 1'b1;
                grant_idx   = IW'(cand);
            end
        end
        if (grant_found) begin
            grant_onehot[grant_idx] = 1'b1;
        end
    end

    assign wb_ready_o = rst_n ? grant_onehot : '0;
    assign grant_addr = wb_addr_i[5*grant_idx +: 5];
    assign grant_data = wb_data_i[XLEN*grant_idx +: XLEN];

    // Writes to x0 are consumed here and never reach the register file.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_reg <= IW'(NUM_SRC - 1);
            wr_en_reg      <= 1'b0;
            wr_addr_reg    <= 5'd0;
            wr_data_reg    <= '0;
        end else begin
            wr_en_reg <= grant_found && (grant_addr != 5'd0);
            if (grant_found) begin
                last_grant_reg <= grant_idx;
            end
            if (grant_found && (grant_addr != 5'd0)) begin
                wr_addr_reg <= grant_addr;
                wr_data_reg <= grant_data;
            end
        end
    end

    assign rf_wr_en_o   = wr_en_reg;
    assign rf_rd_addr_o = wr_addr_reg;
    assign rf_rd_data_o = wr_data_reg;

    // A new issue to a register outranks the retiring write of its old value.
    generate
        for (genvar gi = 1; gi < 32; gi++) begin : g_busy
            logic set_hit;
            logic clr_hit;
            assign set_hit       = issue_valid_i && (issue_rd_i == 5'(gi));
            assign clr_hit       = wr_en_reg && (wr_addr_reg == 5'(gi));
            assign busy_next[gi] = set_hit | (busy_reg[gi] & ~clr_hit);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_reg <= '0;
        end else begin
            busy_reg <= busy_next;
        end
    end

    assign busy_vec   = {busy_reg, 1'b0};
    assign rs1_busy_o = busy_vec[rs1_addr_i];
    assign rs2_busy_o = busy_vec[rs2_addr_i];
    assign rd_busy_o  = busy_vec[rd_addr_i];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: a round-robin reference and a busy-bit
// model feed a queue of expected register file writes checked each cycle.
module tb_regfile_wb_arbiter;

    localparam int NUM_SRC = 3;
    localparam int XLEN    = 64;

    typedef struct {
        logic        en;
        logic [4:0]  addr;
        logic [63:0] data;
    } wr_t;

    logic                    clk;
    logic                    rst_n;
    logic [NUM_SRC-1:0]      wb_valid;
    logic [5*NUM_SRC-1:0]    wb_addr;
    logic [XLEN*NUM_SRC-1:0] wb_data;
    logic [NUM_SRC-1:0]      wb_ready;
    logic                    rf_wr_en;
    logic [4:0]              rf_rd_addr;
    logic [XLEN-1:0]         rf_rd_data;
    logic                    issue_valid;
    logic [4:0]              issue_rd;
    logic [4:0]              rs1_addr, rs2_addr, rd_addr;
    logic                    rs1_busy, rs2_busy, rd_busy;

    logic [4:0]  saddr [NUM_SRC];
    logic [63:0] sdata [NUM_SRC];
    logic [NUM_SRC-1:0] keep;

    wr_t         exp_q[$];
    logic [31:0] busy_m;
    int          lg_m;
    logic        cur_en;
    logic [4:0]  cur_addr;
    int          checks;
    int          errors;

    assign wb_addr = {saddr[2], saddr[1], saddr[0]};
    assign wb_data = {sdata[2], sdata[1], sdata[0]};

    regfile_wb_arbiter #(.NUM_SRC(NUM_SRC), .XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n),
        .wb_valid_i(wb_valid), .wb_addr_i(wb_addr), .wb_data_i(wb_data),
        .wb_ready_o(wb_ready),
        .rf_wr_en_o(rf_wr_en), .rf_rd_addr_o(rf_rd_addr), .rf_rd_data_o(rf_rd_data),
        .issue_valid_i(issue_valid), .issue_rd_i(issue_rd),
        .rs1_addr_i(rs1_addr), .rs2_addr_i(rs2_addr), .rd_addr_i(rd_addr),
        .rs1_busy_o(rs1_busy), .rs2_busy_o(rs2_busy), .rd_busy_o(rd_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [NUM_SRC-1:0] rr_ref(input logic [NUM_SRC-1:0] v, input int lg);
        for (int k = 1; k <= NUM_SRC; k++) begin
            if (v[(lg + k) % NUM_SRC]) return NUM_SRC'(1) << ((lg + k) % NUM_SRC);
        end
        return '0;
    endfunction

    function automatic logic busy_exp(input logic [4:0] a);
        return (a != 5'd0) && busy_m[a];
    endfunction

    task automatic model_reset();
        exp_q.delete();
        busy_m   = '0;
        lg_m     = NUM_SRC - 1;
        cur_en   = 1'b0;
        cur_addr = 5'd0;
    endtask

    // One clock cycle: check grant and busy queries mid-cycle, then the write one edge later.
    task automatic tick();
        logic [NUM_SRC-1:0] er;
        logic [31:0]        nb;
        wr_t                e;
        int                 idx;
        @(negedge clk);
        er = rr_ref(wb_valid, lg_m);
        chk("ready", 64'(wb_ready), 64'(er));
        chk("rs1_busy", 64'(rs1_busy), 64'(busy_exp(rs1_addr)));
        chk("rs2_busy", 64'(rs2_busy), 64'(busy_exp(rs2_addr)));
        chk("rd_busy", 64'(rd_busy), 64'(busy_exp(rd_addr)));
        e.en = 1'b0; e.addr = 5'd0; e.data = '0;
        idx = -1;
        for (int s = 0; s < NUM_SRC; s++) if (er[s]) idx = s;
        if (idx >= 0) begin
            e.en   = (saddr[idx] != 5'd0);
            e.addr = saddr[idx];
            e.data = sdata[idx];
            lg_m   = idx;
        end
        exp_q.push_back(e);
        nb = busy_m;
        if (cur_en) nb[cur_addr] = 1'b0;
        if (issue_valid && issue_rd != 5'd0) nb[issue_rd] = 1'b1;
        @(posedge clk);
        busy_m = nb;
        #1;
        e = exp_q.pop_front();
        $display("cycle t=%0t grant=%b wr_en=%b addr=%0d data=%h", $time, er, rf_wr_en, rf_rd_addr, rf_rd_data);
        chk("wr_en", 64'(rf_wr_en), 64'(e.en));
        if (e.en) begin
            chk("wr_addr", 64'(rf_rd_addr), 64'(e.addr));
            chk("wr_data", rf_rd_data, e.data);
        end
        cur_en   = e.en;
        cur_addr = e.addr;
        if (idx >= 0) begin
            if (keep[idx]) sdata[idx] = sdata[idx] + 64'h1_0000;
            else wb_valid[idx] = 1'b0;
        end
    endtask

    initial begin
        checks = 0; errors = 0;
        rst_n = 1'b0; wb_valid = '0; keep = '0; issue_valid = 1'b0; issue_rd = 5'd0;
        rs1_addr = 5'd0; rs2_addr = 5'd0; rd_addr = 5'd0;
        for (int s = 0; s < NUM_SRC; s++) begin saddr[s] = 5'd0; sdata[s] = '0; end
        model_reset();

        // Reset values; ready stays low during reset even with requests pending.
        #12;
        wb_valid = 3'b111;
        #1;
        chk("rst_ready", 64'(wb_ready), 64'd0);
        chk("rst_wr_en", 64'(rf_wr_en), 64'd0);
        chk("rst_addr", 64'(rf_rd_addr), 64'd0);
        chk("rst_data", rf_rd_data, 64'd0);
        wb_valid = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Single ALU writeback.
        saddr[0] = 5'd7; sdata[0] = 64'hDEADBEEF_00000001; wb_valid = 3'b001;
        tick();
        tick();

        // All sources continuously valid: strict rotation.
        saddr[0] = 5'd20; saddr[1] = 5'd21; saddr[2] = 5'd22;
        sdata[0] = 64'hA0; sdata[1] = 64'hB0; sdata[2] = 64'hC0;
        keep = 3'b111; wb_valid = 3'b111;
        for (int i = 0; i < 6; i++) tick();
        keep = '0; wb_valid = '0;
        tick();

        // Issue rd=12, later MDU retires it.
        issue_valid = 1'b1; issue_rd = 5'd12; rs1_addr = 5'd12; rd_addr = 5'd12;
        tick();
        issue_valid = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        saddr[2] = 5'd12; sdata[2] = 64'h1234_5678_9ABC_DEF0; wb_valid = 3'b100;
        tick();
        tick();
        tick();

        // Retiring write to x3 coincides with a new issue to x3.
        rs2_addr = 5'd3;
        saddr[0] = 5'd3; sdata[0] = 64'h33; wb_valid = 3'b001;
        tick();
        issue_valid = 1'b1; issue_rd = 5'd3; rd_addr = 5'd3;
        tick();
        issue_valid = 1'b0;
        tick();
        saddr[1] = 5'd3; sdata[1] = 64'h333; wb_valid = 3'b010;
        tick();
        tick();
        tick();

        // x0: no busy bit, handshake consumed without a write.
        issue_valid = 1'b1; issue_rd = 5'd0; rs1_addr = 5'd0; rd_addr = 5'd0;
        tick();
        issue_valid = 1'b0;
        saddr[1] = 5'd0; sdata[1] = 64'hFF; wb_valid = 3'b010;
        tick();
        tick();

        // Reset mid-traffic with busy[5] set and a write in flight.
        issue_valid = 1'b1; issue_rd = 5'd5; rd_addr = 5'd5;
        tick();
        issue_valid = 1'b0;
        saddr[0] = 5'd9; sdata[0] = 64'h99; wb_valid = 3'b001;
        tick();
        rst_n = 1'b0;
        wb_valid = 3'b111;
        saddr[0] = 5'd1; saddr[1] = 5'd2; saddr[2] = 5'd4;
        sdata[0] = 64'h10; sdata[1] = 64'h20; sdata[2] = 64'h40;
        #1;
        chk("mid_rst_wr_en", 64'(rf_wr_en), 64'd0);
        chk("mid_rst_addr", 64'(rf_rd_addr), 64'd0);
        chk("mid_rst_data", rf_rd_data, 64'd0);
        chk("mid_rst_busy5", 64'(rd_busy), 64'd0);
        chk("mid_rst_ready", 64'(wb_ready), 64'd0);
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        keep = 3'b111;
        for (int i = 0; i < 3; i++) tick();
        keep = '0; wb_valid = '0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
